// File: rtl/lc_uart_pkg.sv
// Shared UART definitions: FSM state encoding (also used by the TxD side for
// a consistent state_debug view) and framing constants.
package lc_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 87;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Valid/ready byte channel from the UART receiver to the analyzer control FSM.
interface uart_rx_cmd_if;
    import lc_uart_pkg::*;

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/sync_vote3.sv
// Two-flop synchronizer followed by a 3-sample majority filter; idles high.
module sync_vote3 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic       meta_q;
    logic       sync_q;
    logic [2:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            hist_q <= 3'b111;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            hist_q <= {hist_q[1:0], sync_q};
        end
    end

    // A single-clock excursion can only occupy one history slot, so it never wins the vote.
    assign q_o = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_cmd.sv
// 8N1 LSB-first UART receiver delivering host command bytes on a valid/ready
// channel, with frame-error and overrun pulses.
module uart_rx_cmd
    import lc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    uart_rx_cmd_if.master        rx_if,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    logic                 rx_prev_q;
    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 overrun_err_q;
    logic                 busy_q;

    sync_vote3 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (RxD),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q     <= 1'b1;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            rx_prev_q     <= rx_s;
            if (rx_valid_q && rx_if.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            // An accept on this same edge frees the holding register for the new byte.
                            if (!rx_valid_q || rx_if.rx_ready) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_err_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data  = rx_data_q;
    assign rx_if.rx_valid = rx_valid_q;
    assign frame_err      = frame_err_q;
    assign overrun_err    = overrun_err_q;
    assign busy           = busy_q;

endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
- UART receiver, 8N1, LSB first. It is the receive-side counterpart of the analyzer's TxD transmitter.
- Deserialises host command bytes arriving on RxD (trigger mask, sample-rate select, arm/reset) and presents them on a valid/ready byte interface to the analyzer control FSM.
- Runs in the analyzer's system clock domain; RxD is asynchronous to that clock.

Parameters:
- CLKS_PER_BIT, 87, system clocks per bit. 10 MHz / 115200 ≈ 86.8, rounded to 87. Legal range 8..65535.
- CNT_W, 16, width of the bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- RxD  in  1  asynchronous serial input; idle high
- rx_data  out  8  received byte; stable while rx_valid=1
- rx_valid  out  1  byte available; held until accepted
- rx_ready  in  1  consumer accepts the byte when rx_valid & rx_ready on a rising clk edge
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun_err  out  1  one-cycle pulse: byte completed while rx_valid still high
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. On reset:
  - rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0
  - state=IDLE, counters=0
  - synchronizer and vote registers loaded with 1 (line idle)
- Input conditioning:
  - RxD passes through a 2-flop synchronizer, then a 3-bit history shift register.
  - rx_s is the majority vote of the 3 history bits.
  - Total input latency is 3–4 clocks. This is constant, so bit timing is unaffected.
- FSM states are IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: when rx_s falls 1→0, go to START with cnt=0.
  - START: cnt increments each clock. At cnt==CLKS_PER_BIT/2 (integer division):
    - if rx_s==0, go to DATA with cnt=0, bit_idx=0;
    - otherwise it is a glitch/false start, return to IDLE with no error flagged.
  - DATA: at cnt==CLKS_PER_BIT-1, shift rx_s into shift_reg[bit_idx] (LSB first) and set cnt=0. After bit_idx==7 is sampled, go to STOP; otherwise bit_idx++.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1 and rx_valid==0: on the next edge rx_data<=shift_reg, rx_valid<=1, go to IDLE.
    - If 1 and rx_valid==1: rx_data is unchanged, the new byte is dropped, overrun_err pulses for 1 cycle, go to IDLE.
    - If 0: frame_err pulses for 1 cycle, the byte is discarded, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. A break condition never produces spurious bytes.
- Latency:
  - rx_valid rises 1 clock after the stop-bit sample point.
  - The stop-bit sample point is ≈ 9.5 bit times after the start edge, plus input latency.
- Handshake:
  - rx_valid & rx_ready on an edge clears rx_valid on that edge.
  - If acceptance and a new byte's stop-bit commit occur on the same edge, the accept wins first: the new byte is loaded, rx_valid stays 1, no overrun.
  - rx_ready while rx_valid=0 is ignored.
- Sampling: DATA and STOP samples fall at mid-bit, because START consumed half a bit.
- Reset mid-frame: the partial byte is discarded. The next falling edge after reset release starts a fresh frame.
- Width rules:
  - cnt is CNT_W bits and never wraps, because every compare fires before the maximum.
  - bit_idx is 3 bits.

Decomposition:
- Shared package lc_uart_pkg holds:
  - state encoding localparams (IDLE=0 .. WAIT_IDLE=4), reused by the TxD FSM for consistent state_debug encoding
  - default CLKS_PER_BIT and the DATA_BITS=8 constant
- One natural sub-module: sync_vote3, the 2-flop synchronizer plus 3-sample majority filter, reusable for the analyzer's dataIn lines.

Test Plan (bench uses CLKS_PER_BIT=16, clk period 100 ns, bit period 1.6 µs):
- Send 0xA5 with a correct stop bit, rx_ready held 0 → rx_valid=1 with rx_data=0xA5; frame_err=0; rx_valid stays high until rx_ready is pulsed, then drops the same edge.
- Back-to-back 0x01 then 0x80, rx_ready tied 1 → two rx_valid pulses with 0x01 then 0x80; no overrun; busy low only between frames.
- Send 0x3C, leave unaccepted, then send 0xFF → overrun_err one-cycle pulse at the second stop sample; rx_data stays 0x3C.
- Send 0x55 with the stop bit forced low, and the line held low 3 further bit times → frame_err one pulse; no rx_valid; busy high until the line returns high; the next 0x12 frame is received correctly.
- RxD low glitches of 1 and of 5 clocks in IDLE → majority vote rejects the 1-clock glitch with no state change; the 5-clock low enters START, then returns to IDLE at the mid-start check with no outputs asserted.
- Assert rst for 1 cycle during bit 4 of 0xC3 → all outputs return to 0 next edge; a subsequent full 0xC3 frame is received correctly.
